// File: rtl/add_sub_bist_pkg.sv
// Shared definitions for the add_sub_4bit BIST: FSM encoding, vector count
// and the golden add/subtract function used by the reference model.
package add_sub_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  localparam int BIST_WIDTH = 4;
  localparam int NUM_VEC    = 1 << (2*BIST_WIDTH+1);

  // Widest operand the golden function handles; callers truncate the result.
  localparam int MAX_W = 16;
  typedef logic [MAX_W:0] exp_t;

  // Golden result at w+1 bits: cin ? (a + ~b + 1) : (a + b), bit w is cout.
  function automatic exp_t add_sub_exp(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input logic             cin,
                                       input int unsigned      w);
    exp_t mask;
    exp_t bx;
    exp_t s;
    mask = (exp_t'(1) << w) - exp_t'(1);
    bx   = cin ? (~{1'b0, b} & mask) : {1'b0, b};
    s    = {1'b0, a} + bx + exp_t'(cin);
    return s & ((mask << 1) | exp_t'(1));
  endfunction

endpackage

// File: rtl/add_sub_ref_model.sv
// Combinational golden model: expected {cout,sum} for one operand/mode vector.
module add_sub_ref_model
  import add_sub_bist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   exp_o
);

  assign exp_o = (WIDTH+1)'(add_sub_exp(MAX_W'(a_i), MAX_W'(b_i), cin_i, WIDTH));

endmodule

// File: rtl/add_sub_4bit_bist.sv
// Exhaustive on-chip self-test for the add_sub_4bit datapath.
// Sweeps vec_idx = {cin,B,A} through every value, one vector per cycle,
// compares the DUT's {cout,sum} against the golden model and counts
// mismatches in a saturating counter.
// Optional: define ADD_SUB_BIST_FAIL_LOG_EN to add fail_vec/fail_got, which
// record the index and observed result of the first mismatch in a sweep.
module add_sub_4bit_bist
  import add_sub_bist_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2*WIDTH:0]     vec_idx
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
  ,
  output logic [2*WIDTH:0]     fail_vec,
  output logic [WIDTH:0]       fail_got
`endif
);

  localparam int VW = 2*WIDTH + 1;

  bist_state_t          state_q;
  logic [VW-1:0]        vec_q;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 busy_q, done_q, pass_q;
  logic [WIDTH:0]       exp_w, got_w;
  logic                 mismatch;
  logic                 last_vec;

`ifdef ADD_SUB_BIST_FAIL_LOG_EN
  logic                 fail_vld_q;
  logic [VW-1:0]        fail_vec_q;
  logic [WIDTH:0]       fail_got_q;
`endif

  // Vector mapping: A inner loop, B middle, cin outer.
  assign dut_a   = vec_q[WIDTH-1:0];
  assign dut_b   = vec_q[2*WIDTH-1:WIDTH];
  assign dut_cin = vec_q[2*WIDTH];

  add_sub_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i   (vec_q[WIDTH-1:0]),
    .b_i   (vec_q[2*WIDTH-1:WIDTH]),
    .cin_i (vec_q[2*WIDTH]),
    .exp_o (exp_w)
  );

  assign got_w    = {dut_cout, dut_sum};
  assign mismatch = (got_w != exp_w);
  assign last_vec = &vec_q;

  // Next error count: bump on a mismatch while running, holding at all-ones.
  always_comb begin
    err_d = err_q;
    if (state_q == RUN && mismatch && !(&err_q))
      err_d = err_q + ERR_CNT_W'(1);
  end

  // Sweep FSM with vector counter, error counter and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
      fail_got_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            vec_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
            fail_got_q <= '0;
`endif
          end
        end
        RUN: begin
          err_q <= err_d;
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
          if (mismatch && !fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_vec_q <= vec_q;
            fail_got_q <= got_w;
          end
`endif
          if (last_vec) begin
            // Last vector is checked on this edge; vec_idx parks at all-ones.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q <= vec_q + VW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = vec_q;

`ifdef ADD_SUB_BIST_FAIL_LOG_EN
  assign fail_vec = fail_vec_q;
  assign fail_got = fail_got_q;
`endif

endmodule

// File: tb/tb_add_sub_4bit_bist.sv
// Bench for add_sub_4bit_bist: a behavioural adder/subtractor with optional
// stuck-at faults feeds two BIST instances (default and 4-bit error counter);
// expected error counts come from an arithmetic sweep inside the bench.
module tb_add_sub_4bit_bist;

  localparam int W     = 4;
  localparam int ECW   = 10;
  localparam int SECW  = 4;
  localparam int NV    = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  // fault kinds: 0 none, 1 sum bit stuck, 2 cout stuck
  int   f_kind = 0;
  int   f_bit  = 0;
  logic f_val  = 1'b0;

  logic [W-1:0]   a0, b0, sum0;
  logic           cin0, cout0, busy0, done0, pass0;
  logic [ECW-1:0] err0;
  logic [2*W:0]   vidx0;
  logic [W-1:0]   a1, b1, sum1;
  logic           cin1, cout1, busy1, done1, pass1;
  logic [SECW-1:0] err1;
  logic [2*W:0]   vidx1;
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
  logic [2*W:0]   fvec0, fvec1;
  logic [W:0]     fgot0, fgot1;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural adder/subtractor with an optional stuck-at fault.
  function automatic logic [4:0] fdut(input int a, input int b, input int cin,
                                      input int kind, input int bitn, input logic v);
    int r;
    logic [4:0] o;
    r = (cin != 0) ? ((a + 16 - b) & 31) : (a + b);
    o = 5'(r);
    if (kind == 1) o[bitn] = v;
    else if (kind == 2) o[4] = v;
    return o;
  endfunction

  always_comb {cout0, sum0} = fdut(int'(a0), int'(b0), int'(cin0), f_kind, f_bit, f_val);
  always_comb {cout1, sum1} = fdut(int'(a1), int'(b1), int'(cin1), f_kind, f_bit, f_val);

  add_sub_4bit_bist #(.WIDTH(W), .ERR_CNT_W(ECW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(sum0), .dut_cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .vec_idx(vidx0)
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
    , .fail_vec(fvec0), .fail_got(fgot0)
`endif
  );

  add_sub_4bit_bist #(.WIDTH(W), .ERR_CNT_W(SECW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(vidx1)
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
    , .fail_vec(fvec1), .fail_got(fgot1)
`endif
  );

  // Reference: walk the whole vector space with plain arithmetic.
  task automatic ref_sweep(output int cnt, output int first_idx, output int first_got);
    int a, b, c;
    logic [4:0] good, bad;
    cnt = 0; first_idx = 0; first_got = 0;
    for (int i = 0; i < NV; i++) begin
      a = i % 16; b = (i / 16) % 16; c = i / 256;
      good = fdut(a, b, c, 0, 0, 1'b0);
      bad  = fdut(a, b, c, f_kind, f_bit, f_val);
      if (good != bad) begin
        if (cnt == 0) begin first_idx = i; first_got = int'(bad); end
        cnt++;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_err"},  err0,  0);
    chk({tag, "_vidx"}, vidx0, 0);
    chk({tag, "_drv"},  {cin0, b0, a0}, 0);
    chk({tag, "_sat_err"}, err1, 0);
    chk({tag, "_sat_vidx"}, vidx1, 0);
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
    chk({tag, "_fvec"}, fvec0, 0);
    chk({tag, "_fgot"}, fgot0, 0);
`endif
  endtask

  task automatic chk_result(input string tag, input int ecnt, input int fidx, input int fgot);
    int esat;
    esat = (ecnt > 15) ? 15 : ecnt;
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 1);
    chk({tag, "_pass"}, pass0, (ecnt == 0) ? 1 : 0);
    chk({tag, "_err"},  err0,  ecnt);
    chk({tag, "_vidx"}, vidx0, 9'h1FF);
    chk({tag, "_sat_done"}, done1, 1);
    chk({tag, "_sat_err"},  err1,  esat);
    chk({tag, "_sat_pass"}, pass1, (ecnt == 0) ? 1 : 0);
`ifdef ADD_SUB_BIST_FAIL_LOG_EN
    chk({tag, "_fvec"}, fvec0, fidx);
    chk({tag, "_fgot"}, fgot0, fgot);
`else
    if (fidx < 0 || fgot < 0) chk({tag, "_fl"}, 0, 1);
`endif
  endtask

  task automatic run_sweep(input int kind, input int bitn, input logic v,
                           input int abort_at, input bit spam);
    int ecnt, fidx, fgot, cyc;
    f_kind = kind; f_bit = bitn; f_val = v;
    ref_sweep(ecnt, fidx, fgot);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_err_clr",  err0,  0);
    chk("start_done_clr", done0, 0);
    cyc = 0;
    while (busy0 && cyc < NV + 8) begin
      chk("vec_idx", vidx0, cyc);
      chk("drive",   {cin0, b0, a0}, cyc);
      if (cyc == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = spam && ($urandom_range(0, 19) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("busy_cycles", cyc, NV);
    chk_result("sweep", ecnt, fidx, fgot);
    repeat (3) @(negedge clk);
    chk_result("hold", ecnt, fidx, fgot);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    run_sweep(0, 0, 1'b0, -1, 1'b0);                       // clean DUT
    run_sweep(1, 0, 1'b0, -1, 1'b0);                       // sum[0] stuck-at-0
    run_sweep(2, 0, 1'b0, -1, 1'b1);                       // cout stuck-at-0, start spam
    run_sweep(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 100, 1'b0);         // reset mid-run
    @(negedge clk);
    chk_zero("post_abort");
    run_sweep(0, 0, 1'b0, -1, 1'b0);
    for (int k = 0; k < 4; k++)
      run_sweep(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
